mc_control_v2: RTL

- Parametrised next-generation multicycle RV32I control FSM.
- Drives the datapath mux selects and load enables, and talks to a memory port with a `mem_resp` handshake (variable wait states).
- Generates sub-word byte masks for lb/lbu/lh/lhu/sb/sh, and adds jal/jalr.
- Detects illegal opcodes, misaligned accesses and memory timeouts, raising a trap.

---
 rtl/mc_control_v2_if.sv | 47 ++++
 rtl/mc_control_v2.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_v2_if.sv
// Control <-> datapath/memory bundle for the multicycle RV32I controller.
// master = controller side, slave = datapath/memory side.
interface mc_control_v2_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       br_en;
  logic [1:0] addr_lsb;
  logic       mem_resp;

  logic [1:0] pcmux_sel;
  logic       alumux1_sel;
  logic [2:0] alumux2_sel;
  logic [3:0] regfilemux_sel;
  logic       marmux_sel;
  logic       cmpmux_sel;
  logic [2:0] aluop;
  logic [2:0] cmpop;
  logic       load_pc;
  logic       load_ir;
  logic       load_regfile;
  logic       load_mar;
  logic       load_mdr;
  logic       load_data_out;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] mem_byte_enable;
  logic [3:0] rmask;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  opcode, funct3, funct7, br_en, addr_lsb, mem_resp,
    output pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
           cmpmux_sel, aluop, cmpop, load_pc, load_ir, load_regfile, load_mar,
           load_mdr, load_data_out, mem_read, mem_write, mem_byte_enable,
           rmask, trap, trap_cause
  );

  modport slave (
    output opcode, funct3, funct7, br_en, addr_lsb, mem_resp,
    input  pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
           cmpmux_sel, aluop, cmpop, load_pc, load_ir, load_regfile, load_mar,
           load_mdr, load_data_out, mem_read, mem_write, mem_byte_enable,
           rmask, trap, trap_cause
  );
endinterface

// File: rtl/mc_control_v2.sv
// Multicycle RV32I control FSM with sub-word masks, jal/jalr and trap
// detection (illegal opcode, misaligned access, memory timeout).
module mc_control_v2 #(
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned TO_W         = 8,
  parameter int unsigned HALT_ON_TRAP = 1
) (
  input logic            clk,
  input logic            rst,
  mc_control_v2_if.master bus
);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3, DECODE, S_LUI, S_AUIPC, S_IMM, S_REG, S_BR,
    S_JAL, S_JALR, CALC_ADDR, LD1, LD2, ST1, ST2, TRAP
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      lsb_q, lsb_d;
  logic            trap_q;
  logic [1:0]      cause_q, cause_d;
  logic [3:0]      mask;
  logic            misaligned;
  logic            is_store;
  logic            in_wait, enter_wait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH1;
      cnt_q   <= '0;
      lsb_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lsb_q   <= lsb_d;
      // Only the first fault is recorded; trap stays set until reset.
      if (state_d == TRAP && state_q != TRAP && !trap_q) begin
        trap_q  <= 1'b1;
        cause_q <= cause_d;
      end
    end
  end

  always_comb begin
    unique case (bus.funct3[1:0])
      2'b00:   mask = 4'b0001 << lsb_q;
      2'b01:   mask = 4'b0011 << lsb_q;
      default: mask = 4'b1111;
    endcase
  end

  assign is_store   = (bus.opcode == OP_STORE);
  assign misaligned = ((bus.funct3[1:0] == 2'b10) && (bus.addr_lsb != 2'b00)) ||
                      ((bus.funct3[1:0] == 2'b01) && bus.addr_lsb[0]);
  assign in_wait    = (state_q == FETCH2) || (state_q == LD1) || (state_q == ST1);
  assign enter_wait = ((state_d == FETCH2) || (state_d == LD1) || (state_d == ST1)) &&
                      (state_d != state_q);

  always_comb begin
    state_d             = state_q;
    lsb_d               = lsb_q;
    cause_d             = 2'd0;
    bus.pcmux_sel       = 2'd0;
    bus.alumux1_sel     = 1'b0;
    bus.alumux2_sel     = 3'd0;
    bus.regfilemux_sel  = 4'd0;
    bus.marmux_sel      = 1'b0;
    bus.cmpmux_sel      = 1'b0;
    bus.aluop           = bus.funct3;
    bus.cmpop           = bus.funct3;
    bus.load_pc         = 1'b0;
    bus.load_ir         = 1'b0;
    bus.load_regfile    = 1'b0;
    bus.load_mar        = 1'b0;
    bus.load_mdr        = 1'b0;
    bus.load_data_out   = 1'b0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 4'b1111;
    bus.rmask           = 4'b0000;

    unique case (state_q)
      FETCH1: begin
        bus.load_mar = 1'b1;
        state_d      = FETCH2;
      end
      FETCH2: begin
        bus.mem_read = 1'b1;
        bus.load_mdr = 1'b1;
        if (bus.mem_resp)        state_d = FETCH3;
        else if (cnt_q == TO_LAST) begin
          state_d = TRAP;
          cause_d = 2'd2;
        end
      end
      FETCH3: begin
        bus.load_ir = 1'b1;
        state_d     = DECODE;
      end
      DECODE: begin
        unique case (bus.opcode)
          OP_LUI:   state_d = S_LUI;
          OP_AUIPC: state_d = S_AUIPC;
          OP_JAL:   state_d = S_JAL;
          OP_JALR:  state_d = S_JALR;
          OP_BR:    state_d = (bus.funct3[2:1] == 2'b01) ? TRAP : S_BR;
          OP_LOAD:  state_d = (bus.funct3 == 3'd3 || bus.funct3 == 3'd6 ||
                               bus.funct3 == 3'd7) ? TRAP : CALC_ADDR;
          OP_STORE: state_d = (bus.funct3 > 3'd2) ? TRAP : CALC_ADDR;
          OP_IMM:   state_d = S_IMM;
          OP_REG:   state_d = S_REG;
          default:  state_d = TRAP;
        endcase
      end
      S_LUI: begin
        bus.load_regfile   = 1'b1;
        bus.regfilemux_sel = 4'd2;
        bus.load_pc        = 1'b1;
        state_d            = FETCH1;
      end
      S_AUIPC: begin
        bus.alumux1_sel  = 1'b1;
        bus.alumux2_sel  = 3'd1;
        bus.aluop        = 3'd0;
        bus.load_regfile = 1'b1;
        bus.load_pc      = 1'b1;
        state_d          = FETCH1;
      end
      S_IMM, S_REG: begin
        bus.alumux2_sel  = (state_q == S_REG) ? 3'd5 : 3'd0;
        bus.load_regfile = 1'b1;
        bus.load_pc      = 1'b1;
        state_d          = FETCH1;
        if (bus.funct3 == 3'd2 || bus.funct3 == 3'd3) begin
          bus.cmpop          = (bus.funct3 == 3'd2) ? 3'd4 : 3'd6;
          bus.regfilemux_sel = 4'd1;
          bus.cmpmux_sel     = (state_q == S_IMM);
        end else if (bus.funct3 == 3'd5 && bus.funct7 == 7'b0100000) begin
          bus.aluop = 3'd2;
        end else if (state_q == S_REG && bus.funct3 == 3'd0 &&
                     bus.funct7 == 7'b0100000) begin
          bus.aluop = 3'd3;
        end
      end
      S_BR: begin
        bus.alumux1_sel = 1'b1;
        bus.alumux2_sel = 3'd2;
        bus.aluop       = 3'd0;
        bus.pcmux_sel   = {1'b0, bus.br_en};
        bus.load_pc     = 1'b1;
        state_d         = FETCH1;
      end
      S_JAL: begin
        bus.regfilemux_sel = 4'd4;
        bus.load_regfile   = 1'b1;
        bus.alumux1_sel    = 1'b1;
        bus.alumux2_sel    = 3'd4;
        bus.pcmux_sel      = 2'd1;
        bus.load_pc        = 1'b1;
        state_d            = FETCH1;
      end
      S_JALR: begin
        bus.regfilemux_sel = 4'd4;
        bus.load_regfile   = 1'b1;
        bus.pcmux_sel      = 2'd2;
        bus.load_pc        = 1'b1;
        state_d            = FETCH1;
      end
      CALC_ADDR: begin
        bus.aluop       = 3'd0;
        bus.alumux2_sel = is_store ? 3'd3 : 3'd0;
        bus.marmux_sel  = 1'b1;
        lsb_d           = bus.addr_lsb;
        if (misaligned) begin
          state_d = TRAP;
          cause_d = 2'd1;
        end else begin
          bus.load_mar      = 1'b1;
          bus.load_data_out = is_store;
          state_d           = is_store ? ST1 : LD1;
        end
      end
      LD1: begin
        bus.mem_read = 1'b1;
        bus.load_mdr = 1'b1;
        bus.rmask    = mask;
        if (bus.mem_resp)        state_d = LD2;
        else if (cnt_q == TO_LAST) begin
          state_d = TRAP;
          cause_d = 2'd2;
        end
      end
      ST1: begin
        bus.mem_write       = 1'b1;
        bus.mem_byte_enable = mask;
        if (bus.mem_resp)        state_d = ST2;
        else if (cnt_q == TO_LAST) begin
          state_d = TRAP;
          cause_d = 2'd2;
        end
      end
      LD2: begin
        unique case (bus.funct3)
          3'd0:    bus.regfilemux_sel = 4'd5;
          3'd4:    bus.regfilemux_sel = 4'd6;
          3'd1:    bus.regfilemux_sel = 4'd7;
          3'd5:    bus.regfilemux_sel = 4'd8;
          default: bus.regfilemux_sel = 4'd3;
        endcase
        bus.load_regfile = 1'b1;
        bus.load_pc      = 1'b1;
        state_d          = FETCH1;
      end
      ST2: begin
        bus.load_pc = 1'b1;
        state_d     = FETCH1;
      end
      TRAP: begin
        if (HALT_ON_TRAP == 0) begin
          bus.load_pc = 1'b1;
          state_d     = FETCH1;
        end
      end
      default: state_d = FETCH1;
    endcase

    if (enter_wait)                   cnt_d = '0;
    else if (in_wait && !bus.mem_resp) cnt_d = cnt_q + 1'b1;
    else                              cnt_d = cnt_q;
  end

  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
endmodule
